// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: sync pins, scaled pixel coordinates
// and look-ahead strobes for the video pipeline, with run/stop and frame count.
module video_timing_gen #(
  parameter int H_VISIBLE      = 320,
  parameter int H_FRONT        = 8,
  parameter int H_SYNC         = 48,
  parameter int H_BACK         = 24,
  parameter int V_VISIBLE      = 480,
  parameter int V_FRONT        = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BACK         = 33,
  parameter int HSYNC_POS      = 0,
  parameter int VSYNC_POS      = 0,
  parameter int H_SHIFT        = 0,
  parameter int V_SHIFT        = 1,
  parameter int PIPELINE_DELAY = 0,
  parameter int POS_W          = 10,
  parameter int FRAME_W        = 16
) (
  input  logic               clk40,
  input  logic               reset_n,
  input  logic               enable,
  output logic               hsync,
  output logic               vsync,
  output logic               videoActive,
  output logic [POS_W-1:0]   hPos,
  output logic [POS_W-1:0]   vPos,
  output logic [POS_W-1:0]   nextVPos,
  output logic               nextFrameActive,
  output logic               lineStarting,
  output logic               lineEnding,
  output logic               hsyncStarting,
  output logic               frameStarting,
  output logic               vblankStarting,
  output logic [FRAME_W-1:0] frameCount
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);

  localparam logic [HCW-1:0] H_LAST     = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_VIS      = HCW'(H_VISIBLE);
  localparam logic [HCW-1:0] H_VIS_LAST = HCW'(H_VISIBLE - 1);
  localparam logic [HCW-1:0] HS_FIRST   = HCW'(H_VISIBLE + H_FRONT);
  localparam logic [HCW-1:0] HS_LAST    = HCW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [HCW-1:0] LS_H       = HCW'(H_TOTAL - 1 - PIPELINE_DELAY);
  localparam logic [HCW-1:0] LE_H       = HCW'(H_VISIBLE - 1 - PIPELINE_DELAY);
  localparam logic [HCW-1:0] HSS_H      = HCW'(H_VISIBLE + H_FRONT - 1 - PIPELINE_DELAY);

  localparam logic [VCW-1:0] V_LAST     = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_VIS      = VCW'(V_VISIBLE);
  localparam logic [VCW-1:0] V_VIS_LAST = VCW'(V_VISIBLE - 1);
  localparam logic [VCW-1:0] VS_FIRST   = VCW'(V_VISIBLE + V_FRONT);
  localparam logic [VCW-1:0] VS_LAST    = VCW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  localparam logic HS_ON = (HSYNC_POS != 0);
  localparam logic VS_ON = (VSYNC_POS != 0);

  logic               running_q;
  logic [HCW-1:0]     hCount_q, hCount_d;
  logic [VCW-1:0]     vCount_q, vCount_d;
  logic [VCW-1:0]     nextVCount_q, nextVCount_d;
  logic [FRAME_W-1:0] frameCount_q, frameCount_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               hSyncOn, vSyncOn;

  // Stopping (or not yet running) pins the raster at (0,0); syncs are
  // decoded from the next counter values so the pins switch with the counters.
  always_comb begin
    hCount_d     = hCount_q;
    vCount_d     = vCount_q;
    nextVCount_d = nextVCount_q;
    frameCount_d = frameCount_q;
    if (!(enable && running_q)) begin
      hCount_d     = '0;
      vCount_d     = '0;
      nextVCount_d = '0;
    end else begin
      if (hCount_q == H_LAST) begin
        hCount_d = '0;
        vCount_d = nextVCount_q;
        if (vCount_q == V_LAST) begin
          frameCount_d = frameCount_q + FRAME_W'(1);
        end
      end else begin
        hCount_d = hCount_q + HCW'(1);
      end
      if (hCount_q == H_VIS_LAST) begin
        nextVCount_d = (vCount_q == V_LAST) ? '0 : vCount_q + VCW'(1);
      end
    end
    hSyncOn = enable && (hCount_d >= HS_FIRST) && (hCount_d <= HS_LAST);
    vSyncOn = enable && (vCount_d >= VS_FIRST) && (vCount_d <= VS_LAST);
    hsync_d = hSyncOn ? HS_ON : ~HS_ON;
    vsync_d = vSyncOn ? VS_ON : ~VS_ON;
  end

  always_ff @(posedge clk40 or negedge reset_n) begin
    if (!reset_n) begin
      running_q    <= 1'b0;
      hCount_q     <= '0;
      vCount_q     <= '0;
      nextVCount_q <= '0;
      frameCount_q <= '0;
      hsync_q      <= ~HS_ON;
      vsync_q      <= ~VS_ON;
    end else begin
      running_q    <= enable;
      hCount_q     <= hCount_d;
      vCount_q     <= vCount_d;
      nextVCount_q <= nextVCount_d;
      frameCount_q <= frameCount_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
    end
  end

  logic hVis, vVis, nextVis;

  assign hVis    = hCount_q < H_VIS;
  assign vVis    = vCount_q < V_VIS;
  assign nextVis = nextVCount_q < V_VIS;

  assign hsync           = hsync_q;
  assign vsync           = vsync_q;
  assign frameCount      = frameCount_q;
  assign videoActive     = running_q && hVis && vVis;
  assign hPos            = (running_q && hVis) ? POS_W'(hCount_q >> H_SHIFT) : '0;
  assign vPos            = (running_q && vVis) ? POS_W'(vCount_q >> V_SHIFT) : '0;
  assign nextFrameActive = running_q && nextVis;
  assign nextVPos        = nextFrameActive ? POS_W'(nextVCount_q >> V_SHIFT) : '0;
  assign lineStarting    = running_q && (hCount_q == LS_H);
  assign lineEnding      = running_q && (hCount_q == LE_H);
  assign hsyncStarting   = running_q && (hCount_q == HSS_H);
  assign frameStarting   = lineStarting && (vCount_q == V_LAST);
  assign vblankStarting  = running_q && (hCount_q == H_LAST) && (vCount_q == V_VIS_LAST);

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: random run/stop enable against a raster model
// built from elapsed clocks since start; a monitor drains expected outputs.
module tb_video_timing_gen;

  localparam int HV = 16, HF = 2, HS = 3, HB = 3;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME_CLKS = HT * VT;
  localparam int HPOL = 0, VPOL = 1;
  localparam int HSH = 1, VSH = 1, PD = 2;
  localparam int PW = 10, FW = 2;

  typedef struct {
    bit hs, vs, va, nfa, ls, le, hss, fs, vbs;
    int hp, vp, nvp, fc;
  } exp_t;

  logic          clk40   = 1'b0;
  logic          reset_n = 1'b1;
  logic          enable  = 1'b0;
  logic          hsync, vsync, videoActive, nextFrameActive;
  logic          lineStarting, lineEnding, hsyncStarting, frameStarting, vblankStarting;
  logic [PW-1:0] hPos, vPos, nextVPos;
  logic [FW-1:0] frameCount;

  int   cmpCount  = 0;
  int   failCount = 0;
  exp_t expQ[$];
  exp_t monE;
  bit   mRun    = 1'b0;
  int   mT      = 0;
  int   mFrames = 0;

  always #5 clk40 = ~clk40;

  video_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POS(HPOL), .VSYNC_POS(VPOL), .H_SHIFT(HSH), .V_SHIFT(VSH),
    .PIPELINE_DELAY(PD), .POS_W(PW), .FRAME_W(FW)
  ) dut (
    .clk40(clk40), .reset_n(reset_n), .enable(enable),
    .hsync(hsync), .vsync(vsync), .videoActive(videoActive),
    .hPos(hPos), .vPos(vPos), .nextVPos(nextVPos),
    .nextFrameActive(nextFrameActive), .lineStarting(lineStarting),
    .lineEnding(lineEnding), .hsyncStarting(hsyncStarting),
    .frameStarting(frameStarting), .vblankStarting(vblankStarting),
    .frameCount(frameCount)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmpCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Elapsed clocks since the raster last started define the whole state.
  task automatic modelStep(input bit en);
    if (mRun && en) begin
      mT++;
      if (mT % FRAME_CLKS == 0) mFrames++;
    end else begin
      mT = 0;
    end
    mRun = en;
  endtask

  function automatic exp_t computeExp();
    exp_t e;
    int h, v, nv;
    h = mT % HT;
    v = (mT / HT) % VT;
    nv = (h >= HV) ? (v + 1) % VT : v;
    e.hs  = mRun && (h >= HV + HF) && (h < HV + HF + HS);
    e.hs  = (HPOL != 0) ? e.hs : !e.hs;
    e.vs  = mRun && (v >= VV + VF) && (v < VV + VF + VS);
    e.vs  = (VPOL != 0) ? e.vs : !e.vs;
    e.va  = mRun && (h < HV) && (v < VV);
    e.hp  = (mRun && h < HV) ? (h >> HSH) : 0;
    e.vp  = (mRun && v < VV) ? (v >> VSH) : 0;
    e.nfa = mRun && (nv < VV);
    e.nvp = e.nfa ? (nv >> VSH) : 0;
    e.ls  = mRun && (h == HT - 1 - PD);
    e.le  = mRun && (h == HV - 1 - PD);
    e.hss = mRun && (h == HV + HF - 1 - PD);
    e.fs  = e.ls && (v == VT - 1);
    e.vbs = mRun && (h == HT - 1) && (v == VV - 1);
    e.fc  = mFrames % (1 << FW);
    return e;
  endfunction

  task automatic applyStimulus(input int cycles, input bit randomEn);
    int remaining;
    bit en;
    en = 1'b1;
    remaining = randomEn ? int'($urandom_range(60, 700)) : cycles;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk40);
      if (remaining == 0) begin
        if (en) begin
          en = 1'b0;
          remaining = int'($urandom_range(1, 4));
        end else begin
          en = 1'b1;
          remaining = int'($urandom_range(60, 700));
        end
      end
      remaining--;
      enable = en;
      modelStep(en);
      expQ.push_back(computeExp());
    end
  endtask

  initial begin
    forever begin
      @(posedge clk40);
      #2;
      if (expQ.size() > 0) begin
        monE = expQ.pop_front();
        checkOutput("hsync",           32'(hsync),           32'(monE.hs));
        checkOutput("vsync",           32'(vsync),           32'(monE.vs));
        checkOutput("videoActive",     32'(videoActive),     32'(monE.va));
        checkOutput("hPos",            32'(hPos),            32'(monE.hp));
        checkOutput("vPos",            32'(vPos),            32'(monE.vp));
        checkOutput("nextVPos",        32'(nextVPos),        32'(monE.nvp));
        checkOutput("nextFrameActive", 32'(nextFrameActive), 32'(monE.nfa));
        checkOutput("lineStarting",    32'(lineStarting),    32'(monE.ls));
        checkOutput("lineEnding",      32'(lineEnding),      32'(monE.le));
        checkOutput("hsyncStarting",   32'(hsyncStarting),   32'(monE.hss));
        checkOutput("frameStarting",   32'(frameStarting),   32'(monE.fs));
        checkOutput("vblankStarting",  32'(vblankStarting),  32'(monE.vbs));
        checkOutput("frameCount",      32'(frameCount),      32'(monE.fc));
      end
    end
  end

  initial begin
    $display("[TB] start");
    #1 reset_n = 1'b0;
    #2;
    checkOutput("rstHsync",       32'(hsync),       32'(1));
    checkOutput("rstVsync",       32'(vsync),       32'(0));
    checkOutput("rstVideoActive", 32'(videoActive), 32'(0));
    checkOutput("rstHPos",        32'(hPos),        32'(0));
    checkOutput("rstVPos",        32'(vPos),        32'(0));
    checkOutput("rstFrameCount",  32'(frameCount),  32'(0));
    checkOutput("rstLineStart",   32'(lineStarting), 32'(0));
    repeat (2) @(negedge clk40);
    reset_n = 1'b1;

    applyStimulus(1300, 1'b0);
    applyStimulus(4000, 1'b1);
    applyStimulus(37, 1'b0);

    // Mid-line asynchronous reset while running: outputs drop before any edge.
    @(posedge clk40);
    #4;
    reset_n = 1'b0;
    #1;
    checkOutput("midRstHsync",       32'(hsync),       32'(1));
    checkOutput("midRstVsync",       32'(vsync),       32'(0));
    checkOutput("midRstVideoActive", 32'(videoActive), 32'(0));
    checkOutput("midRstHPos",        32'(hPos),        32'(0));
    checkOutput("midRstVPos",        32'(vPos),        32'(0));
    checkOutput("midRstFrameCount",  32'(frameCount),  32'(0));
    enable  = 1'b0;
    mRun    = 1'b0;
    mT      = 0;
    mFrames = 0;
    repeat (2) @(negedge clk40);
    reset_n = 1'b1;

    applyStimulus(1500, 1'b1);
    repeat (2) @(posedge clk40);
    #4;
    checkOutput("queueDrained", 32'(expQ.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", cmpCount, failCount);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Fully parametrised raster timing generator that replaces the fixed 320x480 generator. All porch, sync and polarity values are parameters, and horizontal and vertical pixel replication are set by power-of-two shifts. Adds a run/stop enable, a per-frame counter, and frame-level and vblank advance pulses. Sits at the head of the video pipeline: it drives the sync pins and supplies the pixel coordinates and pipeline look-ahead strobes.

Parameters:
H_VISIBLE, 320, visible pixels per line
H_FRONT, 8, horizontal front porch (clocks)
H_SYNC, 48, hsync width (clocks)
H_BACK, 24, horizontal back porch (clocks)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POS, 0, 1 = hsync active-high
VSYNC_POS, 0, 1 = vsync active-high
H_SHIFT, 0, hPos = hCount >> H_SHIFT
V_SHIFT, 1, vPos = vCount >> V_SHIFT
PIPELINE_DELAY, 0, look-ahead in clocks for the advance strobes; legal range 0..H_VISIBLE-1
POS_W, 10, width of the position outputs
FRAME_W, 16, width of frameCount

Ports:
clk40  in  1  pixel clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  run request; low stops and blanks the raster
hsync  out  1  registered horizontal sync, polarity set by HSYNC_POS
vsync  out  1  registered vertical sync, polarity set by VSYNC_POS
videoActive  out  1  current pixel is visible
hPos  out  POS_W  scaled x position; 0 outside the visible region
vPos  out  POS_W  scaled y position; 0 outside the visible region
nextVPos  out  POS_W  scaled y position of the next line
nextFrameActive  out  1  next line is a visible line
lineStarting  out  1  1-clock strobe PIPELINE_DELAY clocks before a line's first visible pixel
lineEnding  out  1  1-clock strobe PIPELINE_DELAY clocks before a line's last visible pixel
hsyncStarting  out  1  1-clock strobe PIPELINE_DELAY clocks before hsync asserts
frameStarting  out  1  lineStarting qualified to the last line of the frame
vblankStarting  out  1  1-clock strobe on the last clock of the last visible line
frameCount  out  FRAME_W  count of completed frames

Behaviour:
- Derived values: H_TOTAL = sum of the H_* timing values; V_TOTAL = sum of the V_* timing values. Counter widths are $clog2 of each total.
- Reset (reset_n low, asynchronous):
  - running=0, hCount=0, vCount=0, frameCount=0, nextVCount=0.
  - hsync=~HSYNC_POS, vsync=~VSYNC_POS.
  - All strobes 0, videoActive=0, hPos=vPos=nextVPos=0.
- Run control:
  - running <= enable on each clock40 edge.
  - While running=0: counters are held at 0, syncs are inactive, all strobes and videoActive are 0, and frameCount holds.
  - First clock with running=1: hCount=0, vCount=0, so pixel (0,0) is visible. No lineStarting/frameStarting lead is issued for this first line.
  - enable falling mid-frame: on the next edge running=0, counters clear and syncs deassert immediately.
- Counting (running=1):
  - hCount increments and wraps at H_TOTAL-1 -> 0.
  - On that wrap, vCount <= nextVCount and frameCount increments if vCount==V_TOTAL-1. frameCount wraps modulo 2^FRAME_W.
  - nextVCount is registered at hCount==H_VISIBLE-1 as (vCount==V_TOTAL-1 ? 0 : vCount+1). It is valid from hCount==H_VISIBLE to the end of the line.
- Syncs (registered, no glitches):
  - hsync is active for exactly the clocks where hCount is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1].
  - vsync is active for lines vCount in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]. Its edges coincide with hCount==0.
- Combinational outputs, all gated by running:
  - videoActive = (hCount<H_VISIBLE) & (vCount<V_VISIBLE).
  - hPos = (hCount<H_VISIBLE) ? hCount>>H_SHIFT : 0.
  - vPos = (vCount<V_VISIBLE) ? vCount>>V_SHIFT : 0.
  - nextFrameActive = nextVCount<V_VISIBLE; nextVPos is gated by nextFrameActive. All positions are zero-extended or truncated to POS_W.
  - lineStarting: hCount==H_TOTAL-1-PIPELINE_DELAY.
  - lineEnding: hCount==H_VISIBLE-1-PIPELINE_DELAY.
  - hsyncStarting: hCount==H_VISIBLE+H_FRONT-1-PIPELINE_DELAY.
  - frameStarting: lineStarting & vCount==V_TOTAL-1.
  - vblankStarting: hCount==H_TOTAL-1 & vCount==V_VISIBLE-1.
  - Strobes fire on every line, including blanking lines, except frameStarting and vblankStarting, which fire once per frame.
- Simultaneous events: the hCount and vCount wraps and the frameCount increment all occur on the same edge, with no one-clock skew.

Test Plan:
- Reset: hold reset_n low mid-line, with defaults -> hsync=1, vsync=1, videoActive=0, frameCount=0, hPos=vPos=0, asynchronously before the next clock edge. Release -> raster restarts at (0,0) one clock after enable is sampled high.
- Line timing, defaults: hsync low exactly at hCount 328..375 (48 clocks) with a 400-clock period. videoActive high for 320 consecutive clocks on lines 0..479, never on lines 480..524.
- Frame timing: vsync low for lines 490..491 (800 clocks), with edges at hCount==0. Frame period is 210000 clocks. frameCount increments once per frame, and FRAME_W=2 wraps 3->0.
- PIPELINE_DELAY=2: lineStarting at hCount 397, lineEnding at 317, hsyncStarting at 325. frameStarting only on line 524; vblankStarting at line 479, hCount 399.
- Scaling with V_SHIFT=1, H_SHIFT=1: vPos=239 on lines 478..479; hPos=159 at hCount 318..319. nextVPos=1 at line 1, hCount 320, and nextFrameActive=0 on line 479 after hCount 320.
- enable dropped at line 100, hCount 50 -> next clock: syncs inactive, videoActive=0, frameCount held. Re-enable -> pixel (0,0) one clock later, with no spurious strobes.
